video_timing_rx: RTL and testbench
==================================

Name: video_timing_rx

Overview:
Receive-side counterpart to the display timing generator. Takes a pixel-clock-domain hsync/vsync/de stream (our own display output looped back, or an external source) and recovers active-area coordinates plus frame/line strobes. Measures horizontal/vertical total and active sizes and declares lock once the timing is stable and matches the configured mode. Serves as an in-system timing checker and as the front end for future capture into a framebuffer.

Parameters:
CORDW, 12, coordinate/measurement width in bits
H_RES, 1024, required active pixels per line for lock
V_RES, 600, required active lines per frame for lock
HS_POL, 1'b0, hsync active level (0 = active-low)
VS_POL, 1'b0, vsync active level (0 = active-low)
LOCK_FRAMES, 2, consecutive identical, conforming frames required for lock (1..15)

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  reset, asynchronous, active-high
hsync  in  1  incoming horizontal sync (polarity HS_POL)
vsync  in  1  incoming vertical sync (polarity VS_POL)
de  in  1  incoming data enable
rx_de  out  1  de, delayed one cycle, aligned with rx_sx/rx_sy
rx_sx  out  CORDW  active pixel index within line (unsigned)
rx_sy  out  CORDW  active line index within frame (unsigned)
rx_line  out  1  one-cycle pulse on first active pixel of each line
rx_frame  out  1  one-cycle pulse on first active pixel of each frame
h_total  out  CORDW  measured clocks per line (last completed frame)
v_total  out  CORDW  measured lines per frame
h_active  out  CORDW  measured de-high clocks per line
v_active  out  CORDW  measured lines containing de
locked  out  1  timing stable and conforming
err  out  1  one-cycle pulse on loss of lock or timeout

Behaviour:
- Reset (async assert, sync release): every output 0; FSM = SEARCH; all counters and the match count cleared.
- Inputs are registered once (hs_q, vs_q, de_q). Active level: hs_a = (hs_q == HS_POL), vs_a likewise.
- Edge detection: hs leading edge = hs_a & ~hs_a_prev; vs leading edge likewise; de rise = de_q & ~de_q_prev.
- Latency: rx_de/rx_sx/rx_sy/rx_line/rx_frame are valid 2 cycles after the corresponding input cycle.
- rx_sx: 0 on the de-rise cycle; +1 each de-high cycle; holds while de is low.
- rx_sy: 0 on the first de rise after a vs leading edge, +1 on each later de rise.
- rx_frame is asserted together with rx_line on the first line only.
- Coordinates and strobes run in every FSM state, regardless of lock.
- Per-line measurement:
  - hcnt counts clocks between hs leading edges.
  - hact counts de-high clocks in the line.
  - Within one frame, every line's hcnt and hact must equal the first line's; otherwise the frame is marked bad.
- Per-frame measurement:
  - vcnt counts hs leading edges between vs leading edges.
  - vact counts lines that contain at least one de rise.
- All counters saturate at 2^CORDW-1. Saturation marks the frame bad.
- FSM:
  - SEARCH: wait for a vs leading edge, then go to MEASURE with the match count cleared.
  - MEASURE: on each vs leading edge, publish h_total/v_total/h_active/v_active.
    - If the frame is good, h_active==H_RES, v_active==V_RES, and the values equal the previous frame's (first frame counts as a match), increment the match count.
    - Otherwise the match count returns to 0.
    - At match count == LOCK_FRAMES, go to LOCKED and set locked=1.
  - LOCKED: on each vs leading edge, re-check the same conditions. On any failure, set locked=0, pulse err, go to MEASURE with the match count 0.
- Timeout: hcnt saturating (no hs edge for 2^CORDW-1 clocks) in any state forces SEARCH, locked=0, and pulses err if the FSM was LOCKED.
- Simultaneous hs and vs leading edges in one cycle: the line is closed first, then the frame. The line ending at that edge counts toward the closing frame.
- A partial frame after reset is discarded; SEARCH never publishes measurements.

Decomposition:
- Package video_rx_pkg holds:
  - the FSM enum {SEARCH, MEASURE, LOCKED};
  - struct vid_meas_t {h_total, v_total, h_active, v_active}, CORDW-bit each;
  - constant for the saturation value.
- One sub-module, video_period_meas: saturating counter with start/inc/close inputs, captured value, and saturated flag. Instantiated for hcnt, hact, vcnt and vact.

Test Plan:
- Bench uses H_RES=16, V_RES=8, LOCK_FRAMES=2 and synthetic timing: h_total 24, hs width 2, de 16 clocks; v_total 12, vs 1 line.
- Reset mid-frame, then 3 clean frames -> locked rises on the 3rd vs leading edge; h_total=24, v_total=12, h_active=16, v_active=8; err never pulses.
- While locked, one line with de 15 clocks -> at the next vs edge: locked=0, single err pulse; relock after 2 further clean frames.
- Clean frames at h_active=20 -> measurements publish 20, locked stays 0 indefinitely, no err.
- Hold hsync inactive for 4096 clocks while locked -> err pulse and locked=0 at saturation; state returns to SEARCH.
- Coordinate check: rx_frame at rx_sx=0/rx_sy=0, 2 cycles after the first de; rx_sx reaches 15 at line end; rx_sy reaches 7; exactly 8 rx_line pulses per frame.
- Assert rst_pix asynchronously while locked -> all outputs 0 in the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/video_rx_pkg.sv
// Shared types and constants for the video timing receiver.
// Measurement width, FSM encoding and the published measurement record.
package video_rx_pkg;

    localparam int MEAS_W = 12;
    localparam logic [MEAS_W-1:0] MEAS_SAT = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [MEAS_W-1:0] h_total;
        logic [MEAS_W-1:0] v_total;
        logic [MEAS_W-1:0] h_active;
        logic [MEAS_W-1:0] v_active;
    } vid_meas_t;

endpackage

// File: rtl/video_period_meas.sv
// Saturating period counter: accumulates inc_i, captures the running total
// (including this cycle's increment) on close_i and restarts from zero.
module video_period_meas
    import video_rx_pkg::*;
#(
    parameter int W = MEAS_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         inc_i,
    input  logic         close_i,
    output logic [W-1:0] value_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] value_q, value_d;
    logic [W-1:0] sum;

    assign sum = (inc_i && cnt_q != MAX) ? cnt_q + W'(1) : cnt_q;

    always_comb begin
        cnt_d   = sum;
        value_d = value_q;
        if (close_i) begin
            value_d = sum;
            cnt_d   = '0;
        end
        // start discards the running period without publishing it
        if (start_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign sat_o   = (cnt_q == MAX);

endmodule

// File: rtl/video_timing_rx.sv
// Receive-side timing recovery: coordinates/strobes from hsync/vsync/de,
// per-frame timing measurement and lock detection against the configured mode.
module video_timing_rx
    import video_rx_pkg::*;
#(
    parameter int   CORDW       = MEAS_W,
    parameter int   H_RES       = 1024,
    parameter int   V_RES       = 600,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             rx_de,
    output logic [CORDW-1:0] rx_sx,
    output logic [CORDW-1:0] rx_sy,
    output logic             rx_line,
    output logic             rx_frame,
    output logic [CORDW-1:0] h_total,
    output logic [CORDW-1:0] v_total,
    output logic [CORDW-1:0] h_active,
    output logic [CORDW-1:0] v_active,
    output logic             locked,
    output logic             err,
    output rx_state_e        fsm_state
);

    // ---------------- input register and edge detection ----------------
    logic hs_q, vs_q, de_q;
    logic hs_a_prev_q, vs_a_prev_q, de_prev_q;
    logic hs_a, vs_a, hs_lead, vs_lead, de_rise;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            hs_a_prev_q <= 1'b0;
            vs_a_prev_q <= 1'b0;
            de_prev_q   <= 1'b0;
        end else begin
            hs_q        <= hsync;
            vs_q        <= vsync;
            de_q        <= de;
            hs_a_prev_q <= hs_a;
            vs_a_prev_q <= vs_a;
            de_prev_q   <= de_q;
        end
    end

    assign hs_a    = (hs_q == HS_POL);
    assign vs_a    = (vs_q == VS_POL);
    assign hs_lead = hs_a & ~hs_a_prev_q;
    assign vs_lead = vs_a & ~vs_a_prev_q;
    assign de_rise = de_q & ~de_prev_q;

    // ---------------- coordinates and strobes ----------------
    logic             rx_de_q, rx_de_d;
    logic [CORDW-1:0] rx_sx_q, rx_sx_d;
    logic [CORDW-1:0] rx_sy_q, rx_sy_d;
    logic             rx_line_q, rx_line_d;
    logic             rx_frame_q, rx_frame_d;
    logic             first_pend_q, first_pend_d;
    logic             frame_start;

    assign frame_start = first_pend_q | vs_lead;

    always_comb begin
        rx_de_d      = de_q;
        rx_sx_d      = rx_sx_q;
        rx_sy_d      = rx_sy_q;
        rx_line_d    = de_rise;
        rx_frame_d   = de_rise & frame_start;
        first_pend_d = frame_start;
        if (de_rise) begin
            rx_sx_d      = '0;
            rx_sy_d      = frame_start ? '0 : rx_sy_q + CORDW'(1);
            first_pend_d = 1'b0;
        end else if (de_q) begin
            rx_sx_d = rx_sx_q + CORDW'(1);
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            rx_de_q      <= 1'b0;
            rx_sx_q      <= '0;
            rx_sy_q      <= '0;
            rx_line_q    <= 1'b0;
            rx_frame_q   <= 1'b0;
            first_pend_q <= 1'b0;
        end else begin
            rx_de_q      <= rx_de_d;
            rx_sx_q      <= rx_sx_d;
            rx_sy_q      <= rx_sy_d;
            rx_line_q    <= rx_line_d;
            rx_frame_q   <= rx_frame_d;
            first_pend_q <= first_pend_d;
        end
    end

    // ---------------- counters ----------------
    logic             line_de_q, line_de_d;
    logic             timeout;
    logic [CORDW-1:0] h_val, a_val, v_val, va_val;
    logic             h_sat, a_sat, v_sat, va_sat;

    video_period_meas #(.W(CORDW)) u_hcnt (
        .clk_i(clk_pix), .rst_i(rst_pix), .start_i(1'b0),
        .inc_i(1'b1), .close_i(hs_lead), .value_o(h_val), .sat_o(h_sat)
    );
    video_period_meas #(.W(CORDW)) u_hact (
        .clk_i(clk_pix), .rst_i(rst_pix), .start_i(timeout),
        .inc_i(de_q), .close_i(hs_lead), .value_o(a_val), .sat_o(a_sat)
    );
    video_period_meas #(.W(CORDW)) u_vcnt (
        .clk_i(clk_pix), .rst_i(rst_pix), .start_i(timeout),
        .inc_i(hs_lead), .close_i(vs_lead), .value_o(v_val), .sat_o(v_sat)
    );
    video_period_meas #(.W(CORDW)) u_vact (
        .clk_i(clk_pix), .rst_i(rst_pix), .start_i(timeout),
        .inc_i(hs_lead & line_de_q), .close_i(vs_lead), .value_o(va_val), .sat_o(va_sat)
    );

    // hcnt pinned at its ceiling means hsync has gone away
    assign timeout = h_sat;

    // ---------------- line/frame consistency ----------------
    // Captured values appear one cycle after the closing edge, so line and
    // frame evaluation run one cycle late; a line closed together with the
    // frame is evaluated in the same cycle and still counts toward it.
    logic             line_eval_q, line_de_eval_q, frame_eval_q;
    logic [CORDW-1:0] ref_h_q, ref_h_d, ref_a_q, ref_a_d;
    logic             ref_h_pend_q, ref_h_pend_d, ref_a_pend_q, ref_a_pend_d;
    logic             bad_q, bad_d;
    logic             line_bad, frame_bad;

    always_comb begin
        line_bad = 1'b0;
        if (line_eval_q) begin
            if (h_val == MEAS_SAT || (!ref_h_pend_q && h_val != ref_h_q)) begin
                line_bad = 1'b1;
            end
            if (line_de_eval_q &&
                (a_val == MEAS_SAT || (!ref_a_pend_q && a_val != ref_a_q))) begin
                line_bad = 1'b1;
            end
        end
    end

    assign frame_bad = bad_q | line_bad | (v_val == MEAS_SAT) | (va_val == MEAS_SAT);

    always_comb begin
        line_de_d    = line_de_q;
        ref_h_d      = ref_h_q;
        ref_a_d      = ref_a_q;
        ref_h_pend_d = ref_h_pend_q;
        ref_a_pend_d = ref_a_pend_q;
        bad_d        = bad_q | line_bad | a_sat | v_sat | va_sat;
        if (hs_lead) begin
            line_de_d = de_rise;
        end else if (de_rise) begin
            line_de_d = 1'b1;
        end
        if (line_eval_q && ref_h_pend_q) begin
            ref_h_d      = h_val;
            ref_h_pend_d = 1'b0;
        end
        // only lines that carried de set the active-width reference
        if (line_eval_q && line_de_eval_q && ref_a_pend_q) begin
            ref_a_d      = a_val;
            ref_a_pend_d = 1'b0;
        end
        if (frame_eval_q) begin
            ref_h_d      = '0;
            ref_a_d      = '0;
            ref_h_pend_d = 1'b1;
            ref_a_pend_d = 1'b1;
            bad_d        = 1'b0;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            line_de_q      <= 1'b0;
            line_eval_q    <= 1'b0;
            line_de_eval_q <= 1'b0;
            frame_eval_q   <= 1'b0;
            ref_h_q        <= '0;
            ref_a_q        <= '0;
            ref_h_pend_q   <= 1'b1;
            ref_a_pend_q   <= 1'b1;
            bad_q          <= 1'b0;
        end else begin
            line_de_q      <= line_de_d;
            line_eval_q    <= hs_lead;
            line_de_eval_q <= line_de_q;
            frame_eval_q   <= vs_lead;
            ref_h_q        <= ref_h_d;
            ref_a_q        <= ref_a_d;
            ref_h_pend_q   <= ref_h_pend_d;
            ref_a_pend_q   <= ref_a_pend_d;
            bad_q          <= bad_d;
        end
    end

    // ---------------- lock FSM ----------------
    rx_state_e state_q, state_d;
    logic [3:0] match_q, match_d, match_inc;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    vid_meas_t  meas_q, meas_d, cur;
    logic       frame_ok;

    assign cur = '{h_total: ref_h_q, v_total: v_val, h_active: ref_a_q, v_active: va_val};
    assign match_inc = match_q + 4'd1;
    // with no running match the previous frame is not compared
    assign frame_ok = !frame_bad
                   && cur.h_active == MEAS_W'(H_RES)
                   && cur.v_active == MEAS_W'(V_RES)
                   && (match_q == 4'd0 || cur == meas_q);

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        meas_d   = meas_q;
        if (timeout) begin
            state_d  = SEARCH;
            match_d  = 4'd0;
            locked_d = 1'b0;
            err_d    = (state_q == LOCKED);
        end else if (frame_eval_q) begin
            case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                    match_d = 4'd0;
                end
                MEASURE: begin
                    meas_d = cur;
                    if (frame_ok) begin
                        match_d = match_inc;
                        if (match_inc == 4'(LOCK_FRAMES)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                LOCKED: begin
                    meas_d = cur;
                    if (!frame_ok) begin
                        state_d  = MEASURE;
                        match_d  = 4'd0;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    match_d  = 4'd0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q  <= SEARCH;
            match_q  <= 4'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            meas_q   <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            meas_q   <= meas_d;
        end
    end

    assign rx_de     = rx_de_q;
    assign rx_sx     = rx_sx_q;
    assign rx_sy     = rx_sy_q;
    assign rx_line   = rx_line_q;
    assign rx_frame  = rx_frame_q;
    assign h_total   = meas_q.h_total;
    assign v_total   = meas_q.v_total;
    assign h_active  = meas_q.h_active;
    assign v_active  = meas_q.v_active;
    assign locked    = locked_q;
    assign err       = err_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx: 24x12 synthetic timing, 16x8 active.
module tb_video_timing_rx;

    logic             clk_pix = 1'b0;
    logic             rst_pix = 1'b1;
    logic             hsync = 1'b1;
    logic             vsync = 1'b1;
    logic             de = 1'b0;
    logic             rx_de, rx_line, rx_frame, locked, err;
    logic [11:0]      rx_sx, rx_sy, h_total, v_total, h_active, v_active;
    video_rx_pkg::rx_state_e fsm_state;

    video_timing_rx #(
        .CORDW(12), .H_RES(16), .V_RES(8),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix),
        .hsync(hsync), .vsync(vsync), .de(de),
        .rx_de(rx_de), .rx_sx(rx_sx), .rx_sy(rx_sy),
        .rx_line(rx_line), .rx_frame(rx_frame),
        .h_total(h_total), .v_total(v_total),
        .h_active(h_active), .v_active(v_active),
        .locked(locked), .err(err), .fsm_state(fsm_state)
    );

    // clock/reset
    always #5 clk_pix = ~clk_pix;

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int line_cnt = 0;
    int frame_cnt = 0;
    int sx_max = 0;
    int sy_max = 0;
    int frame_sx = -1;
    int frame_sy = -1;
    int frame_cyc = 0;
    int first_de_cyc = 0;

    // output monitor, sampled on the falling edge
    always @(negedge clk_pix) begin
        if (!rst_pix) begin
            if (err) err_cnt++;
            if (rx_line) line_cnt++;
            if (rx_de && int'(rx_sx) > sx_max) sx_max = int'(rx_sx);
            if (rx_de && int'(rx_sy) > sy_max) sy_max = int'(rx_sy);
            if (rx_frame) begin
                frame_cnt++;
                frame_sx  = int'(rx_sx);
                frame_sy  = int'(rx_sy);
                frame_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive_cycle(input logic hs, input logic vs, input logic d);
        @(posedge clk_pix);
        #1;
        hsync = hs;
        vsync = vs;
        de    = d;
    endtask

    task automatic drive_line(input int line, input int de_len);
        logic d;
        for (int c = 0; c < 24; c++) begin
            d = (line >= 2) && (line <= 9) && (c >= 4) && (c < 4 + de_len);
            drive_cycle(c >= 2, line != 0, d);
            if (line == 2 && c == 4) first_de_cyc = cyc;
        end
    endtask

    task automatic drive_frame(input int de_len, input int bad_line);
        line_cnt  = 0;
        frame_cnt = 0;
        sx_max    = 0;
        sy_max    = 0;
        for (int l = 0; l < 12; l++) begin
            drive_line(l, (l == bad_line) ? 15 : de_len);
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk_pix);
        #1;
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_h_total", h_total, 0);
        check("rst_v_total", v_total, 0);
        check("rst_h_active", h_active, 0);
        check("rst_v_active", v_active, 0);
        check("rst_rx_de", rx_de, 0);
        check("rst_rx_frame", rx_frame, 0);
        check("rst_state", fsm_state, video_rx_pkg::SEARCH);
        rst_pix = 1'b0;

        // partial frame after reset, then clean frames
        for (int l = 5; l < 12; l++) drive_line(l, 16);
        drive_frame(16, -1);
        drive_frame(16, -1);
        check("coord_lines", line_cnt, 8);
        check("coord_frames", frame_cnt, 1);
        check("coord_sx_max", sx_max, 15);
        check("coord_sy_max", sy_max, 7);
        check("coord_frame_sx", frame_sx, 0);
        check("coord_frame_sy", frame_sy, 0);
        check("coord_latency", frame_cyc - first_de_cyc, 2);
        check("pre_lock_locked", locked, 0);
        check("pre_lock_state", fsm_state, video_rx_pkg::MEASURE);
        drive_frame(16, -1);
        check("lock_locked", locked, 1);
        check("lock_state", fsm_state, video_rx_pkg::LOCKED);
        check("lock_h_total", h_total, 24);
        check("lock_v_total", v_total, 12);
        check("lock_h_active", h_active, 16);
        check("lock_v_active", v_active, 8);
        check("lock_err_cnt", err_cnt, 0);

        // one short de line while locked
        drive_frame(16, 5);
        check("bad_pending_locked", locked, 1);
        drive_frame(16, -1);
        check("bad_err_cnt", err_cnt, 1);
        check("bad_locked", locked, 0);
        check("bad_state", fsm_state, video_rx_pkg::MEASURE);
        drive_frame(16, -1);
        check("relock_wait_locked", locked, 0);
        drive_frame(16, -1);
        check("relock_locked", locked, 1);
        check("relock_err_cnt", err_cnt, 1);

        // hsync disappears while locked
        drive_idle(4000);
        check("timeout_early_locked", locked, 1);
        check("timeout_early_err", err_cnt, 1);
        drive_idle(100);
        check("timeout_err_cnt", err_cnt, 2);
        check("timeout_locked", locked, 0);
        check("timeout_state", fsm_state, video_rx_pkg::SEARCH);

        // conforming except active width 20
        for (int f = 0; f < 4; f++) drive_frame(20, -1);
        check("wide_h_active", h_active, 20);
        check("wide_h_total", h_total, 24);
        check("wide_v_active", v_active, 8);
        check("wide_v_total", v_total, 12);
        check("wide_locked", locked, 0);
        check("wide_err_cnt", err_cnt, 2);
        check("wide_state", fsm_state, video_rx_pkg::MEASURE);

        // relock, then asynchronous reset mid-line
        for (int f = 0; f < 3; f++) drive_frame(16, -1);
        check("relock2_locked", locked, 1);
        check("relock2_h_active", h_active, 16);
        check("relock2_err_cnt", err_cnt, 2);
        for (int l = 0; l < 4; l++) drive_line(l, 16);
        for (int c = 0; c < 10; c++) drive_cycle(c >= 2, 1'b1, c >= 4);
        check("pre_arst_rx_de", rx_de, 1);
        check("pre_arst_rx_sy", rx_sy, 2);
        #2;
        rst_pix = 1'b1;
        #1;
        check("arst_locked", locked, 0);
        check("arst_err", err, 0);
        check("arst_h_total", h_total, 0);
        check("arst_v_total", v_total, 0);
        check("arst_h_active", h_active, 0);
        check("arst_v_active", v_active, 0);
        check("arst_rx_de", rx_de, 0);
        check("arst_rx_sx", rx_sx, 0);
        check("arst_rx_sy", rx_sy, 0);
        check("arst_state", fsm_state, video_rx_pkg::SEARCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
